// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The state encoding is visible on state_out, so the values are fixed.
package pll_reset_pkg;

    localparam int STATE_W     = 3;
    localparam int LOCK_LOSS_W = 8;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    // Largest of three cycle counts; sizes the shared sequencing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous status inputs.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back stages give the first stage a full cycle to settle.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases
// the system reset. Re-runs on lock loss or relock_req, gives up after
// repeated lock timeouts. Runs only on the free-running reference clock.
// Optional macro PLL_LOCK_LOSS_COUNTER_EN adds a saturating lock_loss_count.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_W        = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked_in,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [STATE_W-1:0] state_out
`ifdef PLL_LOCK_LOSS_COUNTER_EN
    ,
    output logic [LOCK_LOSS_W-1:0] lock_loss_count
`endif
);

    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, sys_reset_q, ready_q, fail_q;
    logic               lock_sync;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked_in),
        .q_o   (lock_sync)
    );

    // Next-state and counter logic; relock_req outranks lock and timeout events.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            PLL_RST: begin
                if (relock_req) begin
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else if (lock_sync) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (relock_req) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else if (!lock_sync) begin
                    // A drop restarts the timeout window without spending a retry.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_sync || relock_req) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs follow the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign state_out   = state_q;

`ifdef PLL_LOCK_LOSS_COUNTER_EN
    logic [LOCK_LOSS_W-1:0] lock_loss_q;

    // Count RUN exits caused by lock loss, saturating; relock_req alone is not a loss.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_q <= '0;
        end else if ((state_q == RUN) && !lock_sync && (lock_loss_q != '1)) begin
            lock_loss_q <= lock_loss_q + LOCK_LOSS_W'(1);
        end
    end

    assign lock_loss_count = lock_loss_q;
`else
    // Without the counter there is no extra state to keep.
`endif

endmodule
